// File: rtl/uart_frame_buffer.sv
// -----------------------------------------------------------------------------
// uart_frame_buffer
//
// Store-and-forward frame buffer between a UART receiver and a UART
// transmitter. Bytes are captured into an indexed memory until the receiver
// signals end of packet, then the whole frame is replayed to the transmitter
// (arrival order, or last byte first when REVERSE=1) using a start/busy
// handshake. Bytes that arrive while the frame is being replayed are dropped
// and counted.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rx_valid   one-cycle strobe, rx_data holds a received byte
//   rx_data    received byte
//   rx_eop     one-cycle strobe, end of packet
//   tx_start   request to transmitter, held until tx_busy is seen high
//   tx_data    byte to transmit, stable while tx_start=1
//   tx_busy    transmitter busy level
//   frame_len  bytes stored in the current/last frame
//   overflow   sticky, current frame exceeded DEPTH
//   draining   high from leaving FILL until the return to FILL
//   drop_cnt   bytes discarded while draining, saturates at 255
// -----------------------------------------------------------------------------
module uart_frame_buffer #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 64,
   parameter int REVERSE = 0,
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_eop,
   output logic              tx_start,
   output logic [DATA_W-1:0] tx_data,
   input  logic              tx_busy,
   output logic [CW-1:0]     frame_len,
   output logic              overflow,
   output logic              draining,
   output logic [7:0]        drop_cnt
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [2:0] {
      S_FILL,
      S_ARM,
      S_LOAD,
      S_START,
      S_WAIT
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [CW-1:0]     r_count, w_count_nxt;
   logic [CW-1:0]     r_sent, w_sent_nxt;
   logic [CW-1:0]     r_frame_len, w_frame_len_nxt;
   logic [AW-1:0]     r_rd, w_rd_nxt;
   logic              r_tx_start, w_tx_start_nxt;
   logic [DATA_W-1:0] r_tx_data, w_tx_data_nxt;
   logic              r_overflow, w_overflow_nxt;
   logic              r_draining, w_draining_nxt;
   logic [7:0]        r_drop_cnt, w_drop_cnt_nxt;
   logic              w_store;
   logic [CW-1:0]     w_cnt_eff;

   logic [DATA_W-1:0] r_mem [DEPTH];

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_comb begin
      w_state_nxt     = r_state;
      w_count_nxt     = r_count;
      w_sent_nxt      = r_sent;
      w_frame_len_nxt = r_frame_len;
      w_rd_nxt        = r_rd;
      w_tx_start_nxt  = r_tx_start;
      w_tx_data_nxt   = r_tx_data;
      w_overflow_nxt  = r_overflow;
      w_draining_nxt  = r_draining;
      w_drop_cnt_nxt  = r_drop_cnt;
      w_store         = 1'b0;
      w_cnt_eff       = r_count;

      case (r_state)
         S_FILL: begin
            if (rx_valid) begin
               if (r_count < DEPTH_C) begin
                  w_store         = 1'b1;
                  w_cnt_eff       = r_count + CW'(1);
                  w_count_nxt     = w_cnt_eff;
                  w_frame_len_nxt = w_cnt_eff;
               end else begin
                  w_overflow_nxt = 1'b1;
               end
            end
            // EOP sees the count including a byte stored in the same cycle
            if (rx_eop && (w_cnt_eff != '0)) begin
               w_state_nxt    = S_ARM;
               w_draining_nxt = 1'b1;
               w_drop_cnt_nxt = 8'd0;
               w_sent_nxt     = '0;
               w_rd_nxt       = (REVERSE != 0) ? AW'(w_cnt_eff - CW'(1)) : '0;
            end
         end
         S_ARM: begin
            if (!tx_busy) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            w_tx_data_nxt  = r_mem[r_rd];
            w_tx_start_nxt = 1'b1;
            w_state_nxt    = S_START;
         end
         S_START: begin
            if (tx_busy) begin
               w_tx_start_nxt = 1'b0;
               w_sent_nxt     = r_sent + CW'(1);
               w_state_nxt    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!tx_busy) begin
               // r_count equals frame_len here; on overflow both are DEPTH
               if (r_sent == r_count) begin
                  w_state_nxt    = S_FILL;
                  w_count_nxt    = '0;
                  w_overflow_nxt = 1'b0;
                  w_draining_nxt = 1'b0;
               end else begin
                  w_rd_nxt    = (REVERSE != 0) ? r_rd - AW'(1) : r_rd + AW'(1);
                  w_state_nxt = S_LOAD;
               end
            end
         end
         default: begin
            w_state_nxt = S_FILL;
         end
      endcase

      if ((r_state != S_FILL) && rx_valid) w_drop_cnt_nxt = sat_inc8(r_drop_cnt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_FILL;
         r_count     <= '0;
         r_sent      <= '0;
         r_frame_len <= '0;
         r_rd        <= '0;
         r_tx_start  <= 1'b0;
         r_tx_data   <= '0;
         r_overflow  <= 1'b0;
         r_draining  <= 1'b0;
         r_drop_cnt  <= 8'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_count     <= w_count_nxt;
         r_sent      <= w_sent_nxt;
         r_frame_len <= w_frame_len_nxt;
         r_rd        <= w_rd_nxt;
         r_tx_start  <= w_tx_start_nxt;
         r_tx_data   <= w_tx_data_nxt;
         r_overflow  <= w_overflow_nxt;
         r_draining  <= w_draining_nxt;
         r_drop_cnt  <= w_drop_cnt_nxt;
      end
   end

   // Frame storage is never reset; only indices below the count are read
   always_ff @(posedge clk) begin
      if (w_store) r_mem[r_count[AW-1:0]] <= rx_data;
   end

   assign tx_start  = r_tx_start;
   assign tx_data   = r_tx_data;
   assign frame_len = r_frame_len;
   assign overflow  = r_overflow;
   assign draining  = r_draining;
   assign drop_cnt  = r_drop_cnt;

endmodule

// File: doc/uart_frame_buffer.md
Name: uart_frame_buffer

Overview:
- Parametrised store-and-forward frame buffer between a UART receiver and a UART transmitter.
- Captures bytes until the receiver's end-of-packet strobe, then replays the whole frame to the transmitter, in forward or reverse order.
- Replaces hand-unrolled per-byte registers with a single indexed memory of configurable width and depth.
- Adds overflow detection, counting of bytes dropped while draining, and status outputs.

Parameters:
- DATA_W, 8, byte width of rx_data/tx_data.
- DEPTH, 64, maximum stored frame length in bytes (≥2, any integer).
- REVERSE, 0, 0 = replay in arrival order; 1 = replay last-received byte first.
- Derived, local, not overridable: AW = $clog2(DEPTH); CW = $clog2(DEPTH+1).

Ports:
- clk  in  1  system clock (42 MHz PLL domain).
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  DATA_W  received byte.
- rx_eop  in  1  one-cycle strobe: line idle after a frame (end of packet).
- tx_start  out  1  request to transmitter; held high until tx_busy is seen high.
- tx_data  out  DATA_W  byte to transmit; stable while tx_start=1.
- tx_busy  in  1  transmitter busy level.
- frame_len  out  CW  number of bytes stored in the current/last frame.
- overflow  out  1  sticky: current frame exceeded DEPTH.
- draining  out  1  high from leaving FILL until return to FILL.
- drop_cnt  out  8  bytes discarded while draining; saturates at 255.

Behaviour:
- Reset (async assert, sync release): state=FILL, wr count=0, rd index=0, tx_start=0, tx_data=0, frame_len=0, overflow=0, draining=0, drop_cnt=0. Memory contents are not reset.
- FILL:
  - rx_valid with count<DEPTH: mem[count] ← rx_data; count++.
  - rx_valid with count==DEPTH: byte discarded; overflow←1.
  - frame_len tracks count.
- rx_valid and rx_eop in the same cycle: the byte is stored first, then the EOP is evaluated with the incremented count.
- rx_eop in FILL:
  - count==0: ignored; stay in FILL.
  - count>0: go to ARM; draining←1; drop_cnt←0.
  - rd index ← 0 when REVERSE=0, count-1 when REVERSE=1.
- ARM: wait for tx_busy=0, then go to LOAD.
- LOAD: one-cycle registered memory read; tx_data←mem[rd]; tx_start←1 on the next edge; go to START.
- START: hold tx_start=1 and tx_data stable until tx_busy=1 is sampled, then tx_start←0 and go to WAIT.
- WAIT: wait for tx_busy=0, then:
  - If bytes sent == frame_len: go to FILL; count←0; overflow←0; draining←0. frame_len keeps its value until the first byte of the next frame.
  - Otherwise: rd ±1 (per REVERSE) and go to LOAD.
- Latency: EOP to first tx_start ≤ 3 cycles when tx_busy=0. Inter-byte gap is governed by the tx_busy handshake.
- While draining (ARM/LOAD/START/WAIT):
  - rx_valid: byte discarded; drop_cnt++ saturating at 255.
  - rx_eop: ignored.
  - drop_cnt holds its value after return to FILL and is cleared only on the next drain start.
- Overflow frame: exactly DEPTH bytes are replayed; overflow stays 1 throughout the drain.
- Index arithmetic: rd never wraps; the last byte is at index 0 (REVERSE=1) or frame_len-1 (REVERSE=0). DEPTH need not be a power of two.
- Reset mid-drain: tx_start drops immediately (async); the frame is abandoned and the next frame starts from empty.
- tx_busy already high in ARM: remain in ARM, do not assert tx_start.

Test Plan:
- REVERSE=0, DEPTH=64: rx 0x41,0x42,0x43 then rx_eop; transmitter model with 10-cycle busy → tx_data sequence 0x41,0x42,0x43; exactly 3 tx_start pulses; draining high throughout; returns to FILL with frame_len=3.
- REVERSE=1: rx 0x01..0x05, eop → tx sequence 0x05,0x04,0x03,0x02,0x01.
- DEPTH=4: rx 6 bytes 0x10..0x15, eop → overflow=1 from the 5th byte; tx 0x10..0x13 only; overflow clears on return to FILL.
- rx_valid(0x7E) and rx_eop in the same cycle after 0x7D → frame_len=2, tx 0x7D,0x7E. Lone rx_eop with empty buffer → no tx_start, state stays FILL.
- During the drain of a 2-byte frame, inject 300 rx_valid strobes plus one rx_eop → drop_cnt=255, no new frame started, buffer empty after the drain.
- Assert rst_n=0 while tx_start=1 → tx_start=0 in the same cycle; after release, rx 0x55 plus eop → single tx 0x55.
